// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg -- shared types and constants for the arbiter
// Revision: 1.0 initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } gnt_t;

    localparam int unsigned C_WAIT_DEFAULT = 2;
    localparam int          C_CNT_W        = 4;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick2 -- two-way round-robin pick, favouring the side not granted last
// Revision: 1.0 initial release
// ============================================================================
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  gnt_t last_gnt,
    output gnt_t winner,
    output logic valid
);

    always_comb begin
        valid  = cpu_req | dbg_req;
        winner = GNT_CPU;
        if (cpu_req && dbg_req) begin
            winner = (last_gnt == GNT_CPU) ? GNT_DBG : GNT_CPU;
        end else if (dbg_req) begin
            winner = GNT_DBG;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter -- CPU/debug round-robin arbiter onto one fixed-latency memory
// Revision: 1.0 initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT = C_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    gnt_t               w_winner;
    logic               w_valid;
    logic               w_we;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;

    state_t             r_state;
    gnt_t               r_last_gnt;
    gnt_t               r_gnt;
    logic [C_CNT_W-1:0] r_cnt;

    rr_pick2 u_pick (
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .last_gnt (r_last_gnt),
        .winner   (w_winner),
        .valid    (w_valid)
    );

    always_comb begin
        w_we    = cpu_we;
        w_addr  = cpu_addr;
        w_wdata = cpu_wdata;
        if (w_winner == GNT_DBG) begin
            w_we    = dbg_we;
            w_addr  = dbg_addr;
            w_wdata = dbg_wdata;
        end
    end

    // The mem_* registers double as the latched transaction fields; they are
    // only non-zero while the access is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_gnt <= GNT_DBG;
            r_gnt      <= GNT_CPU;
            r_cnt      <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    rdata   <= '0;
                    err     <= 1'b0;
                    if (w_valid) begin
                        r_gnt      <= w_winner;
                        r_last_gnt <= w_winner;
                        if (w_addr[1:0] != 2'b00) begin
                            r_state <= DONE;
                            err     <= 1'b1;
                            cpu_ack <= (w_winner == GNT_CPU);
                            dbg_ack <= (w_winner == GNT_DBG);
                        end else begin
                            r_state   <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= w_we;
                            mem_addr  <= w_addr;
                            mem_wdata <= w_wdata;
                            r_cnt     <= C_CNT_W'(WAIT - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        rdata     <= mem_we ? '0 : mem_rdata;
                        cpu_ack   <= (r_gnt == GNT_CPU);
                        dbg_ack   <= (r_gnt == GNT_DBG);
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    rdata   <= '0;
                    err     <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter -- randomized transaction-level check of mem_arbiter
// Revision: 1.0 initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned WAIT    = 2;
    localparam logic [31:0] X_RDATA = 32'h5A5A_1234;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    wire         cpu_ack, dbg_ack, err, mem_en, mem_we;
    wire  [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        x_req;
    wire         a1_cack, a1_dack, a1_err, a1_en, a1_we;
    wire  [31:0] a1_rdata, a1_addr, a1_wdata;
    wire         a15_cack, a15_dack, a15_err, a15_en, a15_we;
    wire  [31:0] a15_rdata, a15_addr, a15_wdata;

    int n_assert = 0;
    int n_fail   = 0;
    bit m_last_dbg;
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT(WAIT)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rdata(rdata), .err(err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WAIT(1)) u_w1 (
        .clk(clk), .reset(reset),
        .cpu_req(x_req), .cpu_we(1'b0), .cpu_addr(32'h40), .cpu_wdata(32'h0), .cpu_ack(a1_cack),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0), .dbg_ack(a1_dack),
        .rdata(a1_rdata), .err(a1_err), .mem_en(a1_en), .mem_we(a1_we),
        .mem_addr(a1_addr), .mem_wdata(a1_wdata), .mem_rdata(X_RDATA)
    );

    mem_arbiter #(.WAIT(15)) u_w15 (
        .clk(clk), .reset(reset),
        .cpu_req(x_req), .cpu_we(1'b0), .cpu_addr(32'h40), .cpu_wdata(32'h0), .cpu_ack(a15_cack),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0), .dbg_ack(a15_dack),
        .rdata(a15_rdata), .err(a15_err), .mem_en(a15_en), .mem_we(a15_we),
        .mem_addr(a15_addr), .mem_wdata(a15_wdata), .mem_rdata(X_RDATA)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Memory model: read data is only meaningful in the last enabled cycle of
    // a burst; earlier cycles return a recognisable junk value.
    logic [31:0] mem [0:255];
    int          en_run = 0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
            en_run <= 0;
        end else if (mem_en) begin
            en_run <= en_run + 1;
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        end else begin
            en_run <= 0;
        end
    end
    assign mem_rdata = (mem_en && !mem_we && en_run == int'(WAIT) - 1) ?
                       mem[mem_addr[9:2]] : (32'hBAD0_0000 | 32'(en_run));

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        m_last_dbg = 1'b1;
    endtask

    task automatic clear_reqs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        x_req = 0;
    endtask

    // Runs one or two concurrent requests to completion and checks every cycle
    // against a transaction-level timeline built up front.
    task automatic run_pair(input bit c_on, input bit c_we, input logic [31:0] c_addr, input logic [31:0] c_wd,
                            input bit d_on, input bit d_we, input logic [31:0] d_addr, input logic [31:0] d_wd,
                            input bit scramble);
        int          n, t, s [2], a [2];
        bit          f_dbg [2], f_we [2], f_mis [2];
        logic [31:0] f_addr [2], f_wd [2], f_rd [2];
        bit          exp_c, exp_d, exp_en, is_ack, exp_err;
        logic [31:0] exp_rd;
        logic [64:0] exp_bus;
        n        = (c_on && d_on) ? 2 : 1;
        f_dbg[0] = (c_on && d_on) ? !m_last_dbg : d_on;
        f_dbg[1] = !f_dbg[0];
        for (int k = 0; k < n; k++) begin
            f_we[k]   = f_dbg[k] ? d_we   : c_we;
            f_addr[k] = f_dbg[k] ? d_addr : c_addr;
            f_wd[k]   = f_dbg[k] ? d_wd   : c_wd;
            f_mis[k]  = (f_addr[k][1:0] != 2'b00);
            f_rd[k]   = (!f_mis[k] && !f_we[k]) ? ref_mem[f_addr[k][9:2]] : 32'h0;
            if (!f_mis[k] && f_we[k]) ref_mem[f_addr[k][9:2]] = f_wd[k];
            s[k]      = (k == 0) ? 0 : a[0] + 1;
            a[k]      = s[k] + (f_mis[k] ? 1 : int'(WAIT) + 1);
            m_last_dbg = f_dbg[k];
        end
        @(negedge clk);
        cpu_req = c_on; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dbg_req = d_on; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
        for (t = 1; t <= a[n-1]; t++) begin
            @(negedge clk);
            exp_c = 0; exp_d = 0; exp_en = 0; is_ack = 0; exp_err = 0; exp_rd = 0; exp_bus = '0;
            for (int k = 0; k < n; k++) begin
                if (!f_mis[k] && t > s[k] && t <= s[k] + int'(WAIT)) begin
                    exp_en  = 1;
                    exp_bus = {f_we[k], f_addr[k], f_wd[k]};
                end
                if (t == a[k]) begin
                    is_ack = 1; exp_err = f_mis[k]; exp_rd = f_rd[k];
                    if (f_dbg[k]) exp_d = 1; else exp_c = 1;
                end
            end
            n_assert++;
            if ({cpu_ack, dbg_ack} !== {exp_c, exp_d}) begin
                n_fail++; $display("FAIL acks t=%0d got=%b%b exp=%b%b", t, cpu_ack, dbg_ack, exp_c, exp_d);
            end
            n_assert++;
            if (mem_en !== exp_en) begin
                n_fail++; $display("FAIL mem_en t=%0d got=%b exp=%b", t, mem_en, exp_en);
            end
            if (exp_en) begin
                n_assert++;
                if ({mem_we, mem_addr, mem_wdata} !== exp_bus) begin
                    n_fail++; $display("FAIL mem_bus t=%0d got=%h exp=%h", t, {mem_we, mem_addr, mem_wdata}, exp_bus);
                end
            end
            n_assert++;
            if ({rdata, err} !== {exp_rd, exp_err}) begin
                n_fail++; $display("FAIL %s t=%0d got=%h/%b exp=%h/%b", is_ack ? "ack_data" : "idle_data",
                                   t, rdata, err, exp_rd, exp_err);
            end
            if (scramble && t < a[0]) begin
                if (f_dbg[0]) begin dbg_addr = $urandom; dbg_wdata = $urandom; dbg_we = 1'($urandom); end
                else          begin cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom); end
            end
            if (exp_c) cpu_req = 0;
            if (exp_d) dbg_req = 0;
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        reset = 1;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            n_assert++;
            if ({cpu_ack, dbg_ack, err, mem_en, mem_we} !== 5'b0) begin
                n_fail++; $display("FAIL reset_ctl phase=%0d got=%b exp=00000", p, {cpu_ack, dbg_ack, err, mem_en, mem_we});
            end
            n_assert++;
            if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin
                n_fail++; $display("FAIL reset_data phase=%0d got=%h exp=0", p, {rdata, mem_addr, mem_wdata});
            end
            reset = 0;
            model_reset();
            @(negedge clk);
        end
    endtask

    task automatic test_dbg_write();
        run_pair(0, 0, 32'h0, 32'h0, 1, 1, 32'h200, 32'h1234_5678, 0);
    endtask

    task automatic test_cpu_read();
        run_pair(1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 0);
        run_pair(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        run_pair(0, 0, 32'h0, 32'h0, 1, 0, 32'h200, 32'h0, 0);
    endtask

    task automatic test_misaligned();
        run_pair(1, 0, 32'h102, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        run_pair(0, 0, 32'h0, 32'h0, 1, 1, 32'h203, 32'hFFFF_FFFF, 0);
        run_pair(1, 0, 32'h201, 32'h0, 1, 0, 32'h200, 32'h0, 0);
    endtask

    task automatic test_contention();
        int nack = 0;
        bit who;
        clear_reqs();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; model_reset();
        cpu_req = 1; cpu_addr = 32'h10;
        dbg_req = 1; dbg_addr = 32'h20;
        for (int t = 1; t <= 60 && nack < 4; t++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                who = (nack % 2 == 1);
                n_assert++;
                if ({cpu_ack, dbg_ack} !== {!who, who}) begin
                    n_fail++; $display("FAIL rr_order n=%0d got=%b%b exp=%b%b", nack, cpu_ack, dbg_ack, !who, who);
                end
                n_assert++;
                if (t !== int'(WAIT) + 1 + nack * (int'(WAIT) + 2)) begin
                    n_fail++; $display("FAIL rr_time n=%0d got=%0d exp=%0d", nack, t, int'(WAIT) + 1 + nack * (int'(WAIT) + 2));
                end
                n_assert++;
                if (rdata !== ref_mem[who ? 8 : 4]) begin
                    n_fail++; $display("FAIL rr_rdata n=%0d got=%h exp=%h", nack, rdata, ref_mem[who ? 8 : 4]);
                end
                nack++;
                if (nack == 4) begin cpu_req = 0; dbg_req = 0; end
            end
        end
        n_assert++;
        if (nack !== 4) begin
            n_fail++; $display("FAIL rr_count got=%0d exp=4", nack);
        end
        clear_reqs();
    endtask

    task automatic test_ignore_changes();
        run_pair(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        run_pair(1, 1, 32'h44, 32'hA1A2_A3A4, 1, 1, 32'h48, 32'hB1B2_B3B4, 1);
        run_pair(1, 0, 32'h44, 32'h0, 1, 0, 32'h48, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  on;
            logic [31:0] ca, da;
            on = 2'($urandom_range(1, 3));
            ca = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            da = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 5) == 0) ca[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) da[1:0] = 2'($urandom_range(1, 3));
            run_pair(on[0], 1'($urandom), ca, $urandom, on[1], 1'($urandom), da, $urandom,
                     ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        @(negedge clk);
        n_assert++;
        if (mem_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_en got=%b exp=1", mem_en);
        end
        reset = 1;
        @(negedge clk);
        n_assert++;
        if ({mem_en, cpu_ack, dbg_ack} !== 3'b000) begin
            n_fail++; $display("FAIL mid_rst got=%b exp=000", {mem_en, cpu_ack, dbg_ack});
        end
        reset = 0; cpu_req = 0; model_reset();
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            n_assert++;
            if ({mem_en, cpu_ack, dbg_ack} !== 3'b000) begin
                n_fail++; $display("FAIL mid_quiet t=%0d got=%b exp=000", t, {mem_en, cpu_ack, dbg_ack});
            end
        end
        run_pair(1, 0, 32'h8, 32'h0, 1, 0, 32'hC, 32'h0, 0);
    endtask

    task automatic test_wait_builds();
        int t1 = -1, t15 = -1;
        @(negedge clk);
        x_req = 1;
        for (int t = 1; t <= 40 && (t1 < 0 || t15 < 0); t++) begin
            @(negedge clk);
            if (a1_cack && t1 < 0) begin
                t1 = t;
                n_assert++;
                if (a1_rdata !== X_RDATA) begin
                    n_fail++; $display("FAIL w1_rdata got=%h exp=%h", a1_rdata, X_RDATA);
                end
            end
            if (a15_cack && t15 < 0) begin
                t15 = t;
                n_assert++;
                if (a15_rdata !== X_RDATA) begin
                    n_fail++; $display("FAIL w15_rdata got=%h exp=%h", a15_rdata, X_RDATA);
                end
            end
        end
        x_req = 0;
        n_assert++;
        if (t1 !== 2) begin
            n_fail++; $display("FAIL w1_latency got=%0d exp=2", t1);
        end
        n_assert++;
        if (t15 !== 16) begin
            n_fail++; $display("FAIL w15_latency got=%0d exp=16", t15);
        end
    endtask

    initial begin
        reset = 1;
        clear_reqs();
        test_reset();
        test_dbg_write();
        test_cpu_read();
        test_misaligned();
        test_contention();
        test_ignore_changes();
        test_random();
        test_reset_mid();
        test_wait_builds();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
